// File: rtl/fir2d_kernel.sv
// fir2d_kernel: streaming 2D FIR over a TAP_NUMS x TAP_NUMS window built from
// vertical input columns, with replicate padding at the left and right line
// edges, a three-stage registered datapath and rounding/saturation to the
// pixel width.
module fir2d_kernel #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TAP_NUMS   = 3,
    parameter int unsigned LINE_CNT   = 12,
    parameter int unsigned COEF_WIDTH = 8,
    parameter int unsigned SHIFT      = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       col_en_i,
    input  logic [TAP_NUMS*DATA_WIDTH-1:0]             col_data_i,
    input  logic [LINE_CNT-1:0]                        h_size_i,
    input  logic [TAP_NUMS*TAP_NUMS*COEF_WIDTH-1:0]    coef_i,
    output logic                                       out_en_o,
    output logic [DATA_WIDTH-1:0]                      out_data_o,
    output logic                                       out_last_o,
    output logic                                       err_o
);

    localparam int unsigned P      = (TAP_NUMS - 1) / 2;
    localparam int unsigned NT     = TAP_NUMS * TAP_NUMS;
    localparam int unsigned SLOT_W = TAP_NUMS * DATA_WIDTH;
    localparam int unsigned WIN_W  = TAP_NUMS * SLOT_W;
    localparam int unsigned CALL_W = NT * COEF_WIDTH;
    localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int unsigned GUARD  = $clog2(NT);
    localparam int unsigned SUM_W  = PROD_W + GUARD;
    // One extra bit so the rounding constant can never wrap the sum.
    localparam int unsigned ACC_W  = SUM_W + 1;
    localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [ACC_W-1:0] RND  = (SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
    localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) << DATA_WIDTH) - ACC_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [LINE_CNT-1:0]       r_col_cnt;
    logic [LINE_CNT-1:0]       w_col_cnt_nxt;
    logic [LINE_CNT-1:0]       r_flush_cnt;
    logic [LINE_CNT-1:0]       w_flush_cnt_nxt;
    logic [LINE_CNT-1:0]       r_h_size;
    logic [LINE_CNT-1:0]       w_h_size_nxt;
    logic [CALL_W-1:0]         r_coef;
    logic [CALL_W-1:0]         w_coef_nxt;
    logic [WIN_W-1:0]          r_win;
    logic [WIN_W-1:0]          w_win_nxt;
    logic                      r_win_vld;
    logic                      r_win_last;
    logic                      w_eval;
    logic                      w_eval_last;
    logic                      r_err;
    logic                      w_err_set;

    logic [LINE_CNT-1:0]       w_col_idx;
    logic                      w_h_short;
    logic [LINE_CNT-1:0]       w_h_eff;

    logic signed [PROD_W-1:0]  w_prod [NT];
    logic signed [PROD_W-1:0]  r_prod [NT];
    logic                      r_prod_vld;
    logic                      r_prod_last;

    logic signed [ACC_W-1:0]   w_acc;
    logic signed [ACC_W-1:0]   w_shr;
    logic [DATA_WIDTH-1:0]     w_sat;

    logic                      r_out_en;
    logic [DATA_WIDTH-1:0]     r_out_data;
    logic                      r_out_last;

    // Index of the column being accepted in RUN and the effective line length.
    assign w_col_idx = r_col_cnt + LINE_CNT'(1);
    assign w_h_short = (h_size_i < LINE_CNT'(TAP_NUMS));
    assign w_h_eff   = w_h_short ? LINE_CNT'(TAP_NUMS) : h_size_i;

    // Next-state, window shift and evaluation-issue logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_col_cnt_nxt   = r_col_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        w_h_size_nxt    = r_h_size;
        w_coef_nxt      = r_coef;
        w_win_nxt       = r_win;
        w_eval          = 1'b0;
        w_eval_last     = 1'b0;
        w_err_set       = 1'b0;
        case (r_state)
            IDLE: begin
                if (col_en_i) begin
                    // Column 0 fills every slot: left-edge replicate padding.
                    w_win_nxt     = {TAP_NUMS{col_data_i}};
                    w_col_cnt_nxt = '0;
                    w_h_size_nxt  = w_h_eff;
                    w_coef_nxt    = coef_i;
                    w_err_set     = w_h_short;
                    if (w_h_eff == LINE_CNT'(1)) begin
                        w_state_nxt     = FLUSH;
                        w_flush_cnt_nxt = LINE_CNT'(P);
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (col_en_i) begin
                    w_win_nxt     = {col_data_i, r_win[WIN_W-1:SLOT_W]};
                    w_col_cnt_nxt = w_col_idx;
                    w_eval        = (w_col_idx >= LINE_CNT'(P));
                    if (w_col_idx == r_h_size - LINE_CNT'(1)) begin
                        w_state_nxt     = FLUSH;
                        w_flush_cnt_nxt = LINE_CNT'(P);
                    end
                end
            end
            FLUSH: begin
                // Right-edge replicate padding: re-shift the newest column.
                w_win_nxt       = {r_win[WIN_W-1 -: SLOT_W], r_win[WIN_W-1:SLOT_W]};
                w_flush_cnt_nxt = r_flush_cnt - LINE_CNT'(1);
                w_eval          = 1'b1;
                w_err_set       = col_en_i;
                if (r_flush_cnt == LINE_CNT'(1)) begin
                    w_state_nxt = IDLE;
                    w_eval_last = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control state, window and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_col_cnt   <= '0;
            r_flush_cnt <= '0;
            r_h_size    <= '0;
            r_coef      <= '0;
            r_win       <= '0;
            r_win_vld   <= 1'b0;
            r_win_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col_cnt   <= w_col_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_h_size    <= w_h_size_nxt;
            r_coef      <= w_coef_nxt;
            r_win       <= w_win_nxt;
            r_win_vld   <= w_eval;
            r_win_last  <= w_eval_last;
            r_err       <= r_err | w_err_set;
        end
    end

    // Signed products: window slot c pairs with coefficient column c.
    always_comb begin
        for (int r = 0; r < int'(TAP_NUMS); r++) begin
            for (int c = 0; c < int'(TAP_NUMS); c++) begin
                w_prod[r*TAP_NUMS + c] =
                    PROD_W'($signed({1'b0, r_win[(c*TAP_NUMS + r)*DATA_WIDTH +: DATA_WIDTH]}))
                  * PROD_W'($signed(r_coef[(r*TAP_NUMS + c)*COEF_WIDTH +: COEF_WIDTH]));
            end
        end
    end

    // Product pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NT); i++) begin
                r_prod[i] <= '0;
            end
            r_prod_vld  <= 1'b0;
            r_prod_last <= 1'b0;
        end else begin
            r_prod_vld  <= r_win_vld;
            r_prod_last <= r_win_last;
            if (r_win_vld) begin
                for (int i = 0; i < int'(NT); i++) begin
                    r_prod[i] <= w_prod[i];
                end
            end
        end
    end

    // Sum, round, arithmetic shift and clamp to the pixel range.
    always_comb begin
        w_acc = RND;
        for (int i = 0; i < int'(NT); i++) begin
            w_acc = w_acc + ACC_W'(r_prod[i]);
        end
        w_shr = w_acc >>> SHIFT;
        if (w_shr < 0) begin
            w_sat = '0;
        end else if (w_shr > MAXV) begin
            w_sat = '1;
        end else begin
            w_sat = DATA_WIDTH'(w_shr);
        end
    end

    // Output stage; data holds between valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_en   <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_out_en   <= r_prod_vld;
            r_out_last <= r_prod_vld & r_prod_last;
            if (r_prod_vld) begin
                r_out_data <= w_sat;
            end
        end
    end

    assign out_en_o   = r_out_en;
    assign out_data_o = r_out_data;
    assign out_last_o = r_out_last;
    assign err_o      = r_err;

endmodule

// File: tb/tb_fir2d_kernel.sv
// tb_fir2d_kernel: directed and randomized lines against a behavioural
// per-line model; expected pixels are queued and a monitor checks them.
module tb_fir2d_kernel;

    localparam int DW = 8;
    localparam int T  = 3;
    localparam int LC = 12;
    localparam int CW = 8;
    localparam int SH = 4;
    localparam int P  = (T - 1) / 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic                  col_en;
    logic [T*DW-1:0]       col_data;
    logic [LC-1:0]         h_size;
    logic [T*T*CW-1:0]     coef;
    logic                  out_en;
    logic [DW-1:0]         out_data;
    logic                  out_last;
    logic                  err;

    exp_t   q[$];
    int     pix [64][T];
    int     cf  [T][T];
    int     n_chk;
    int     n_pass;
    int     cyc;
    int     acc_cyc;
    int     first_out_cyc;
    bit     lat_arm;
    logic [DW-1:0] hold_exp;

    fir2d_kernel #(
        .DATA_WIDTH (DW),
        .TAP_NUMS   (T),
        .LINE_CNT   (LC),
        .COEF_WIDTH (CW),
        .SHIFT      (SH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .col_en_i   (col_en),
        .col_data_i (col_data),
        .h_size_i   (h_size),
        .coef_i     (coef),
        .out_en_o   (out_en),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: every output j is the 2D sum centred on column j with
    // column indices clamped into the line, then rounded, shifted, clamped.
    function automatic void model_line(input int h);
        exp_t e;
        int   acc;
        int   k;
        for (int j = 0; j < h; j++) begin
            acc = 0;
            for (int r = 0; r < T; r++) begin
                for (int c = 0; c < T; c++) begin
                    k = j - P + c;
                    if (k < 0) k = 0;
                    if (k > h - 1) k = h - 1;
                    acc += cf[r][c] * pix[k][r];
                end
            end
            if (SH > 0) acc += (1 << (SH - 1));
            acc = acc >>> SH;
            if (acc < 0) acc = 0;
            if (acc > 255) acc = 255;
            e.d = DW'(acc);
            e.l = (j == h - 1);
            q.push_back(e);
        end
    endfunction

    // tail: 0 normal flush wait, 1 poke col_en in first flush cycle, 2 none.
    task automatic run_line(input int h_in, input int ncols, input int stall_max, input int tail);
        h_size = LC'(h_in);
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++)
                coef[(r*T + c)*CW +: CW] = CW'(cf[r][c]);
        for (int k = 0; k < ncols; k++) begin
            if (k > 0 && stall_max > 0) begin
                repeat ($urandom_range(0, stall_max)) begin
                    col_en = 1'b0;
                    @(posedge clk); #1;
                end
            end
            col_en = 1'b1;
            for (int r = 0; r < T; r++) col_data[r*DW +: DW] = DW'(pix[k][r]);
            @(posedge clk); #1;
            if (k == P) acc_cyc = cyc;
        end
        col_en = 1'b0;
        if (tail != 2) begin
            for (int f = 0; f < P; f++) begin
                if (tail == 1 && f == 0) begin
                    col_en   = 1'b1;
                    col_data = T*DW'($urandom);
                end
                @(posedge clk); #1;
                col_en = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        col_en = 1'b0;
        q.delete();
        #1;
        chk("rst_out_en", out_en, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_cf(input int centre, input int other);
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++)
                cf[r][c] = (r == P && c == P) ? centre : other;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output pulse, checks hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_exp = '0;
        end else if (out_en) begin
            if (lat_arm) begin
                first_out_cyc = cyc;
                lat_arm       = 1'b0;
            end
            if (q.size() == 0) begin
                chk("unexpected_out_en", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_last", out_last, e.l);
                hold_exp = e.d;
            end
        end else begin
            chk("out_hold", out_data, hold_exp);
            chk("last_idle", out_last, 0);
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; acc_cyc = 0; first_out_cyc = 0;
        lat_arm = 1'b0; hold_exp = '0;
        rst = 1'b1; col_en = 1'b0; col_data = '0; h_size = '0; coef = '0;
        @(posedge clk); #1;
        do_reset();

        // Identity kernel, centre lanes 10,20,30,40.
        set_cf(16, 0);
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < T; r++) pix[k][r] = int'($urandom_range(0, 255));
            pix[k][P] = 10 * (k + 1);
        end
        model_line(4);
        lat_arm = 1'b1;
        run_line(4, 4, 0, 0);
        drain();
        chk("latency_edges", first_out_cyc - acc_cyc, 2);
        chk("err_clean", err, 0);

        // Edge replicate: column k is uniformly k+1 -> 12,18,27,33.
        set_cf(16, 16);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < T; r++) pix[k][r] = k + 1;
        model_line(4);
        run_line(4, 4, 0, 0);
        drain();

        // Saturation high.
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < T; r++) pix[k][r] = 100;
        model_line(4);
        run_line(4, 4, 0, 0);
        drain();

        // Clamp low with all-negative coefficients.
        set_cf(-1, -1);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < T; r++) pix[k][r] = int'($urandom_range(1, 255));
        model_line(4);
        run_line(4, 4, 0, 0);
        drain();

        // Rounding: 3*8 = 24, (24+8)>>4 = 2.
        set_cf(8, 0);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < T; r++) pix[k][r] = 3;
        model_line(4);
        run_line(4, 4, 0, 0);
        drain();

        // Column during FLUSH: dropped, error set, four outputs still.
        set_cf(5, 2);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < T; r++) pix[k][r] = int'($urandom_range(0, 255));
        model_line(4);
        run_line(4, 4, 0, 1);
        drain();
        chk("err_flush_poke", err, 1);
        drain();
        chk("err_sticky", err, 1);

        // Short line: h_size 2 processed as 3 columns.
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < T; r++) pix[k][r] = int'($urandom_range(0, 255));
        model_line(3);
        run_line(2, 3, 0, 0);
        drain();
        chk("err_short", err, 1);

        // Reset after column 2, then a normal line right after release.
        run_line(4, 3, 0, 2);
        do_reset();
        set_cf(3, 1);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < T; r++) pix[k][r] = int'($urandom_range(0, 255));
        model_line(4);
        run_line(4, 4, 0, 0);
        drain();
        chk("err_after_reset", err, 0);

        // Random lines, back to back, with stalls.
        for (int n = 0; n < 20; n++) begin
            int h;
            h = int'($urandom_range(3, 12));
            for (int r = 0; r < T; r++)
                for (int c = 0; c < T; c++) cf[r][c] = int'($urandom_range(0, 12)) - 4;
            for (int k = 0; k < h; k++)
                for (int r = 0; r < T; r++) pix[k][r] = int'($urandom_range(0, 255));
            model_line(h);
            run_line(h, h, 2, 0);
        end
        drain();
        drain();
        chk("queue_empty", q.size(), 0);
        chk("err_random", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
